pulse_train_gen: RTL and testbench



---
 rtl/pulse_gen_pkg.sv | 20 ++
 rtl/phase_counter.sv | 49 ++++
 rtl/pulse_train_gen.sv | 197 +++++++++++++++++++
 tb/tb_pulse_train_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared types and defaults for pulse_train_gen and its phase counter.
//   pg_state_e : train FSM state (IDLE / ACTIVE / GAP), 2-bit encoding
//   CNT_W_DEF  : default phase-counter width (cycles)
//   NUM_W_DEF  : default pulse-counter width
// No ports; imported with "import pulse_gen_pkg::*;".
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned NUM_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } pg_state_e;

endpackage : pulse_gen_pkg

// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Loadable down-counter with terminal-count flag; times one phase (high or
// low) of the pulse train.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset, clears the count
//   clr_i      : synchronous clear (highest priority)
//   load_i     : load load_val_i on the next edge
//   load_val_i : phase length in cycles (never 0 when loaded)
//   en_i       : decrement enable; the count holds at 0
//   tc_o       : high while the count is 1, i.e. the last cycle of the phase
// -----------------------------------------------------------------------------
module phase_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == W'(1));

endmodule : phase_counter

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// Drives a pulse train on signal_out from programmed high/low lengths and a
// pulse count, latched on an accepted start. Start/busy/done/err handshake.
// Optional macro PULSE_TRAIN_EDGE_STROBE_EN adds registered rise_out/fall_out
// strobes marking 0->1 / 1->0 transitions of signal_out.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : train request, sampled only in IDLE
//   abort        : stop the train, honoured in any cycle (wins over start)
//   high_len     : active-phase length in cycles
//   low_len      : idle-phase length in cycles
//   pulse_cnt    : number of pulses
//   signal_out   : registered waveform (IDLE_LEVEL when idle / in gap)
//   busy         : high from the cycle after accept until the train ends
//   done         : one-cycle pulse on normal completion
//   err          : one-cycle pulse on a start with a zero field
//   rise_out     : (macro only) 1 in the cycle signal_out first shows 0->1
//   fall_out     : (macro only) 1 in the cycle signal_out first shows 1->0
// -----------------------------------------------------------------------------
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned NUM_W      = NUM_W_DEF,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] pulse_cnt,
   output logic             signal_out,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef PULSE_TRAIN_EDGE_STROBE_EN
   ,
   output logic             rise_out,
   output logic             fall_out
`endif
);

   pg_state_e        state_q, state_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [NUM_W-1:0] pulse_q, pulse_d;
   logic             sig_q, sig_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             ph_clr, ph_load, ph_en, ph_tc;
   logic [CNT_W-1:0] ph_val;

   logic             fields_ok;
   assign fields_ok = (high_len != '0) && (low_len != '0) && (pulse_cnt != '0);

   phase_counter #(.W(CNT_W)) u_phase (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (ph_clr),
      .load_i     (ph_load),
      .load_val_i (ph_val),
      .en_i       (ph_en),
      .tc_o       (ph_tc)
   );

   // Next-state/output decode; the phase counter is reloaded in the same
   // cycle the state changes so each phase lasts exactly its programmed length.
   always_comb begin
      state_d = state_q;
      high_d  = high_q;
      low_d   = low_q;
      pulse_d = pulse_q;
      sig_d   = sig_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ph_clr  = 1'b0;
      ph_load = 1'b0;
      ph_en   = 1'b0;
      ph_val  = high_q;

      if (abort) begin
         // In IDLE this is a no-op apart from dropping a same-cycle start.
         state_d = IDLE;
         sig_d   = IDLE_LEVEL;
         busy_d  = 1'b0;
         pulse_d = '0;
         ph_clr  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (fields_ok) begin
                     high_d  = high_len;
                     low_d   = low_len;
                     pulse_d = pulse_cnt;
                     ph_load = 1'b1;
                     ph_val  = high_len;
                     state_d = ACTIVE;
                     sig_d   = !IDLE_LEVEL;
                     busy_d  = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (ph_tc) begin
                  ph_load = 1'b1;
                  ph_val  = low_q;
                  state_d = GAP;
                  sig_d   = IDLE_LEVEL;
               end else begin
                  ph_en = 1'b1;
               end
            end
            GAP: begin
               if (ph_tc) begin
                  if (pulse_q > NUM_W'(1)) begin
                     pulse_d = pulse_q - NUM_W'(1);
                     ph_load = 1'b1;
                     ph_val  = high_q;
                     state_d = ACTIVE;
                     sig_d   = !IDLE_LEVEL;
                  end else begin
                     pulse_d = '0;
                     state_d = IDLE;
                     sig_d   = IDLE_LEVEL;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  ph_en = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               sig_d   = IDLE_LEVEL;
               busy_d  = 1'b0;
               ph_clr  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         high_q  <= '0;
         low_q   <= '0;
         pulse_q <= '0;
         sig_q   <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         high_q  <= high_d;
         low_q   <= low_d;
         pulse_q <= pulse_d;
         sig_q   <= sig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign signal_out = sig_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

`ifdef PULSE_TRAIN_EDGE_STROBE_EN
   // Strobes are registered from the same next-value as signal_out so they
   // line up with the cycle in which the new level first appears.
   logic rise_q, fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= sig_d & ~sig_q;
         fall_q <= ~sig_d & sig_q;
      end
   end

   assign rise_out = rise_q;
   assign fall_out = fall_q;
`endif

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
// Cycle-by-cycle directed vectors for pulse_train_gen (IDLE_LEVEL=0), plus
// hand-written sequences for asynchronous reset mid-train, a maximum pulse
// count, and (with PULSE_TRAIN_EDGE_STROBE_EN) edge strobes at IDLE_LEVEL=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

   localparam int unsigned CW = 16;
   localparam int unsigned NW = 8;

   logic          clk;
   logic          rst_n;
   logic          start, abort;
   logic [CW-1:0] high_len, low_len;
   logic [NW-1:0] pulse_cnt;
   logic          signal_out, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PULSE_TRAIN_EDGE_STROBE_EN
   logic          rise_out, fall_out;
   logic          s_start;
   logic [CW-1:0] s_high, s_low;
   logic [NW-1:0] s_cnt;
   logic          s_sig, s_busy, s_done, s_err, s_rise, s_fall;
`endif

   pulse_train_gen #(
      .CNT_W      (CW),
      .NUM_W      (NW),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .high_len   (high_len),
      .low_len    (low_len),
      .pulse_cnt  (pulse_cnt),
      .signal_out (signal_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
`ifdef PULSE_TRAIN_EDGE_STROBE_EN
      ,
      .rise_out   (rise_out),
      .fall_out   (fall_out)
`endif
   );

`ifdef PULSE_TRAIN_EDGE_STROBE_EN
   pulse_train_gen #(
      .CNT_W      (CW),
      .NUM_W      (NW),
      .IDLE_LEVEL (1'b1)
   ) dut_inv (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (s_start),
      .abort      (1'b0),
      .high_len   (s_high),
      .low_len    (s_low),
      .pulse_cnt  (s_cnt),
      .signal_out (s_sig),
      .busy       (s_busy),
      .done       (s_done),
      .err        (s_err),
      .rise_out   (s_rise),
      .fall_out   (s_fall)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          start;
      logic          abort;
      logic [CW-1:0] h;
      logic [CW-1:0] l;
      logic [NW-1:0] n;
      logic          sig;
      logic          busy;
      logic          done;
      logic          err;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic st, input logic ab,
                               input int h, input int l, input int n,
                               input logic sig, input logic bsy,
                               input logic dn, input logic er);
      vec_t v;
      v.start = st;  v.abort = ab;
      v.h = CW'(h);  v.l = CW'(l);  v.n = NW'(n);
      v.sig = sig;   v.busy = bsy;  v.done = dn;  v.err = er;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Starts a train and counts busy cycles at falling edges, bounded.
   task automatic run_train(input int h, input int l, input int n, input int limit,
                            output int cyc, output logic [31:0] pat,
                            output logic done_seen);
      @(negedge clk);
      start = 1'b1; high_len = CW'(h); low_len = CW'(l); pulse_cnt = NW'(n);
      @(negedge clk);
      start = 1'b0; high_len = '0; low_len = '0; pulse_cnt = '0;
      cyc = 0;
      pat = '0;
      while (busy === 1'b1 && cyc < limit) begin
         pat = {pat[30:0], signal_out};
         cyc++;
         @(negedge clk);
      end
      done_seen = done;
   endtask

   initial begin
      int          cyc;
      logic [31:0] pat;
      logic        dseen;

      start = 1'b0; abort = 1'b0;
      high_len = '0; low_len = '0; pulse_cnt = '0;
`ifdef PULSE_TRAIN_EDGE_STROBE_EN
      s_start = 1'b0; s_high = '0; s_low = '0; s_cnt = '0;
`endif
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      chk("reset_sig",  32'(signal_out), 32'd0);
      chk("reset_busy", 32'(busy),       32'd0);
      chk("reset_done", 32'(done),       32'd0);
      chk("reset_err",  32'(err),        32'd0);
      rst_n = 1'b1;

      // Basic train H=3 L=2 N=2; a start while busy (cycle 2) is ignored
      add(1,0,3,2,2, 0,0,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(1,0,1,1,1, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,0,0,0);
      // Rejected starts: low_len, high_len, pulse_cnt zero
      add(1,0,3,0,2, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,2,2, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,1);
      add(1,0,3,2,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,1);
      add(0,0,0,0,0, 0,0,0,0);
      // abort + start in IDLE: abort wins, no err, no train
      add(1,1,3,2,2, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      // H=5 L=5 N=4, abort in cycle 7 (gap)
      add(1,0,5,5,4, 0,0,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      // abort during the active phase
      add(1,0,5,5,4, 0,0,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,1,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      // Back-to-back: restart in the done cycle with H=1 L=1 N=3
      add(1,0,1,1,1, 0,0,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(1,0,1,1,3, 0,0,1,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 1,1,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,0,0,0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         start = vq[i].start; abort = vq[i].abort;
         high_len = vq[i].h;  low_len = vq[i].l;  pulse_cnt = vq[i].n;
         chk($sformatf("vec%0d_sig",  i), 32'(signal_out), 32'(vq[i].sig));
         chk($sformatf("vec%0d_busy", i), 32'(busy),       32'(vq[i].busy));
         chk($sformatf("vec%0d_done", i), 32'(done),       32'(vq[i].done));
         chk($sformatf("vec%0d_err",  i), 32'(err),        32'(vq[i].err));
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      high_len = '0; low_len = '0; pulse_cnt = '0;

      // Asynchronous reset mid-ACTIVE with H=100
      @(negedge clk);
      start = 1'b1; high_len = CW'(100); low_len = CW'(3); pulse_cnt = NW'(1);
      @(negedge clk);
      start = 1'b0; high_len = '0; low_len = '0; pulse_cnt = '0;
      repeat (5) @(negedge clk);
      chk("pre_rst_sig",  32'(signal_out), 32'd1);
      chk("pre_rst_busy", 32'(busy),       32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sig",  32'(signal_out), 32'd0);
      chk("async_rst_busy", 32'(busy),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full train after reset: H=2 L=1 N=2 -> 1,1,0,1,1,0
      run_train(2, 1, 2, 50, cyc, pat, dseen);
      chk("post_rst_busy_cycles", 32'(cyc), 32'd6);
      chk("post_rst_pattern",     pat,      32'b110110);
      chk("post_rst_done",        32'(dseen), 32'd1);
      @(negedge clk);
      chk("post_rst_done_1cyc",   32'(done), 32'd0);

      // Maximum pulse count, H=1 L=1 N=255
      run_train(1, 1, 255, 600, cyc, pat, dseen);
      chk("max_cnt_busy_cycles", 32'(cyc), 32'd510);
      chk("max_cnt_tail",        pat[7:0], 32'b10101010);
      chk("max_cnt_done",        32'(dseen), 32'd1);

`ifdef PULSE_TRAIN_EDGE_STROBE_EN
      // IDLE_LEVEL=1, H=2 L=2 N=1: fall in cycle 1, rise in cycle 3 only
      @(negedge clk);
      s_start = 1'b1; s_high = CW'(2); s_low = CW'(2); s_cnt = NW'(1);
      chk("strobe_c0_rise", 32'(s_rise), 32'd0);
      chk("strobe_c0_fall", 32'(s_fall), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         s_start = 1'b0; s_high = '0; s_low = '0; s_cnt = '0;
         chk($sformatf("strobe_c%0d_rise", k), 32'(s_rise), 32'(k == 3));
         chk($sformatf("strobe_c%0d_fall", k), 32'(s_fall), 32'(k == 1));
         chk($sformatf("strobe_c%0d_sig",  k), 32'(s_sig),  32'(!(k == 1 || k == 2)));
      end

      // Abort-forced return to idle also strobes (IDLE_LEVEL=0 instance)
      @(negedge clk);
      start = 1'b1; high_len = CW'(5); low_len = CW'(5); pulse_cnt = NW'(2);
      @(negedge clk);
      start = 1'b0; high_len = '0; low_len = '0; pulse_cnt = '0;
      chk("abort_rise", 32'(rise_out), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_fall", 32'(fall_out), 32'd1);
      chk("abort_sig",  32'(signal_out), 32'd0);
      @(negedge clk);
      chk("abort_fall_1cyc", 32'(fall_out), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pulse_train_gen
